// File: rtl/pot_smoother_if.sv
// Sample-clock / ADC-result / filtered-value bundle between the ADC interface,
// pot_smoother and the downstream control-voltage consumer.
interface pot_smoother_if;
    logic       sample_clk;
    logic [9:0] adc_data;
    logic [9:0] value;
    logic       value_valid;

    modport master (
        output sample_clk,
        output value,
        output value_valid,
        input  adc_data
    );

    modport slave (
        input  sample_clk,
        input  value,
        input  value_valid,
        output adc_data
    );
endinterface

// File: rtl/pot_smoother.sv
// ADC sample-clock generator, power-of-two moving average and hysteresis gate
// producing a jitter-free 10-bit control value with a one-cycle update strobe.
module pot_smoother #(
    parameter int unsigned CLK_DIV  = 2048,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned HYST     = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    pot_smoother_if.master bus
);
    localparam int unsigned DW    = 10;
    localparam int unsigned N     = 1 << AVG_LOG2;
    localparam int unsigned SW    = DW + AVG_LOG2;
    localparam int unsigned DIV_W = 16;
    localparam logic [DW-1:0] MAX_CODE = '1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [DIV_W-1:0]    div;
    logic                sclk;
    logic                div_tc_c;
    logic [DW-1:0]       cap;
    logic                cap_v;
    logic [DW-1:0]       ring [N];
    logic [AVG_LOG2-1:0] wp;
    logic [SW-1:0]       sum;
    logic                sum_v;
    logic [0:0]          state, state_nxt;
    logic [AVG_LOG2-1:0] fill_cnt, fill_cnt_nxt;
    logic [DW-1:0]       value_q, value_nxt;
    logic                valid_q, valid_nxt;
    logic [DW-1:0]       avg_c;
    logic signed [DW:0]  diff_c;
    logic [DW:0]         mag_c;
    logic                change_c;

    assign div_tc_c = (div == DIV_W'(CLK_DIV - 1));

    // Sample clock: toggles every CLK_DIV cycles, 50% duty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (div_tc_c) begin
            div  <= '0;
            sclk <= ~sclk;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Capture the conversion result in the falling-edge cycle only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap   <= '0;
            cap_v <= 1'b0;
        end else begin
            cap_v <= div_tc_c & sclk;
            if (div_tc_c && sclk) begin
                cap <= bus.adc_data;
            end
        end
    end

    // Running sum over the last N captures; the oldest entry is retired as the new one lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                ring[i] <= '0;
            end
            wp    <= '0;
            sum   <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_v <= cap_v;
            if (cap_v) begin
                ring[wp] <= cap;
                sum      <= sum + SW'(cap) - SW'(ring[wp]);
                wp       <= wp + AVG_LOG2'(1);
            end
        end
    end

    assign avg_c  = sum[SW-1:AVG_LOG2];
    assign diff_c = $signed({1'b0, avg_c}) - $signed({1'b0, value_q});
    assign mag_c  = diff_c[DW] ? $unsigned(-diff_c) : $unsigned(diff_c);

    // Rail codes bypass hysteresis so 0 and full scale stay reachable
    assign change_c = (mag_c > (DW+1)'(HYST)) ||
                      (((avg_c == '0) || (avg_c == MAX_CODE)) && (avg_c != value_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            fill_cnt <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
            value_q  <= value_nxt;
            valid_q  <= valid_nxt;
        end
    end

    // FILL waits for a full window before the first unconditional publish
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        value_nxt    = value_q;
        valid_nxt    = 1'b0;
        case (state)
            FILL: begin
                if (sum_v) begin
                    fill_cnt_nxt = fill_cnt + AVG_LOG2'(1);
                    if (fill_cnt == '1) begin
                        state_nxt = RUN;
                        value_nxt = avg_c;
                        valid_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (sum_v && change_c) begin
                    value_nxt = avg_c;
                    valid_nxt = 1'b1;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign bus.sample_clk  = sclk;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
endmodule

// File: tb/tb_pot_smoother.sv
// Directed bench for pot_smoother: the driver queues hand-computed publishes,
// a negedge monitor pops them whenever value_valid fires.
module tb_pot_smoother;
    localparam int unsigned CLK_DIV = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pot_smoother_if bus();

    pot_smoother #(
        .CLK_DIV  (CLK_DIV),
        .AVG_LOG2 (3),
        .HYST     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] v;
        int         k;
    } exp_t;

    exp_t       expq[$];
    exp_t       got_e;
    int         compared   = 0;
    int         mismatched = 0;
    int         pk         = 0;
    int         fall_idx   = 0;
    bit         abort      = 1'b0;
    logic [9:0] prev_value = '0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, pk);
        end
    endtask

    // Cycle index since reset release: value seen at a negedge belongs to cycle pk
    always @(posedge clk) begin
        if (!reset_n) pk = 0;
        else          pk = pk + 1;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            case (pk)
                1, 255, 512, 767, 1024: check("sclk_low", int'(bus.sample_clk), 0);
                256, 511, 768, 1023:    check("sclk_high", int'(bus.sample_clk), 1);
                default: ;
            endcase
            if (bus.value_valid) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pulse: got value %0d at cycle %0d, wanted no pulse",
                             bus.value, pk);
                end else begin
                    got_e = expq.pop_front();
                    check("pulse_value", int'(bus.value), int'(got_e.v));
                    check("pulse_cycle", pk, got_e.k);
                end
            end
            if (bus.value != prev_value) begin
                check("value_change_has_strobe", int'(bus.value_valid), 1);
            end
        end
        prev_value = bus.value;
    end

    task automatic wait_level(input logic lvl);
        int n = 0;
        while (!abort && bus.sample_clk !== lvl) begin
            @(negedge clk);
            n++;
            if (n > 3 * CLK_DIV) begin
                compared++;
                mismatched++;
                $display("FAIL sclk_timeout: got no sample_clk=%0b after %0d cycles, wanted it within %0d",
                         lvl, n, 3 * CLK_DIV);
                abort = 1'b1;
            end
        end
    endtask

    // One ADC sample: true data during the high phase, noise while low
    task automatic run_sample(input int d, input bit p, input int v);
        if (abort) return;
        wait_level(1'b1);
        if (abort) return;
        bus.adc_data = 10'(d);
        wait_level(1'b0);
        if (abort) return;
        fall_idx++;
        if (fall_idx == 1) check("first_fall_cycle", pk, 2 * CLK_DIV);
        if (fall_idx == 8) check("eighth_fall_cycle", pk, 16 * CLK_DIV);
        bus.adc_data = 10'($urandom);
        if (p) expq.push_back('{10'(v), pk + 2});
    endtask

    task automatic end_phase(input string name, input int hold_v);
        repeat (4) @(negedge clk);
        check("pending_pulses", expq.size(), 0);
        check(name, int'(bus.value), hold_v);
    endtask

    task automatic reset_mid_high();
        wait_level(1'b1);
        repeat (CLK_DIV / 2) @(negedge clk);
        check("sclk_high_before_reset", int'(bus.sample_clk), 1);
        #1 reset_n = 1'b0;
        #1;
        check("reset_sclk", int'(bus.sample_clk), 0);
        check("reset_value", int'(bus.value), 0);
        check("reset_valid", int'(bus.value_valid), 0);
        repeat (3) @(negedge clk);
        expq.delete();
        fall_idx = 0;
        reset_n  = 1'b1;
    endtask

    int down_v[8] = '{895, 767, 639, 511, 383, 255, 127, 0};

    initial begin
        bus.adc_data = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_state_value", int'(bus.value), 0);
        check("reset_state_sclk", int'(bus.sample_clk), 0);
        reset_n = 1'b1;

        // Constant 512: one publish after the window fills, then silence
        for (int i = 1; i <= 50; i++) run_sample(512, i == 8, 512);
        // Step to 520 with hysteresis 2
        for (int k = 1; k <= 12; k++) run_sample(520, (k == 3) || (k == 6), (k == 3) ? 515 : 518);
        end_phase("hold_518", 518);

        reset_mid_high();

        // Top rail reachable only through the force rule
        for (int i = 1; i <= 8; i++) run_sample(1021, i == 8, 1021);
        for (int k = 1; k <= 8; k++) run_sample(1023, k == 8, 1023);
        end_phase("top_1023", 1023);
        for (int k = 0; k < 8; k++) run_sample(0, 1'b1, down_v[k]);
        end_phase("bottom_0", 0);
        // Publish 5, drop to 2, then force to 0 when the 2 ages out
        for (int k = 1; k <= 17; k++) begin
            run_sample((k == 1) ? 40 : (k == 9) ? 16 : 0,
                       (k == 1) || (k == 9) || (k == 17),
                       (k == 1) ? 5 : (k == 9) ? 2 : 0);
        end
        end_phase("force_0", 0);

        reset_mid_high();

        // Alternating 500/502 averages to a steady 501
        for (int i = 1; i <= 20; i++) run_sample((i % 2 == 1) ? 500 : 502, i == 8, 501);
        end_phase("jitter_501", 501);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
